rotl_iter: RTL and testbench
============================

# rotl_iter

Iterative rotate-left unit for the BMI ALU: the left-direction counterpart of the combinational rotate-right datapath. It accepts one operand and shift amount per valid/ready transfer. It rotates left by `shift_in[SHAMT_WIDTH-1:0]` using one log-stage per cycle, so only a single 2:1 mux column is needed instead of a full mux tree per bit. The result is held on a valid/ready output port until it is consumed.

## Interface
- `DATA_WIDTH`, 256: operand width. It must equal 2**`SHAMT_WIDTH`.
- `SHAMT_WIDTH`, 8: number of low bits of `shift_in` that are used. It is also the fixed iteration count.
- `clk`  input  1  rising-edge clock; the only clock in the block.
- `rst_n`  input  1  asynchronous, active-low reset.
- `enable`  input  1  step enable. When low, iteration in BUSY is frozen. Handshakes are unaffected.
- `in_valid`  input  1  `a_in` and `shift_in` are valid.
- `in_ready`  output  1  block can accept an operand.
- `a_in`  input  `DATA_WIDTH`  operand.
- `shift_in`  input  `DATA_WIDTH`  rotate amount. Only bits `[SHAMT_WIDTH-1:0]` are used; upper bits are ignored.
- `out_valid`  output  1  `a_out` holds a completed result.
- `out_ready`  input  1  consumer accepts the result.
- `a_out`  output  `DATA_WIDTH`  rotated result, registered.
- `busy`  output  1  high in BUSY.

## Operation
- FSM states are IDLE, BUSY and DONE. Registers are `work[DATA_WIDTH-1:0]`, `shamt[SHAMT_WIDTH-1:0]` and stage counter `k[$clog2(SHAMT_WIDTH+1)-1:0]`.
- `in_ready` is combinational: `(state==IDLE) || (state==DONE && out_ready)`.
- **Accept**, when `in_valid && in_ready`:
  - `work <= a_in`, `shamt <= shift_in[SHAMT_WIDTH-1:0]`, `k <= 0`.
  - State goes to BUSY, in both the IDLE and DONE cases.
- **BUSY, `enable` high:**
  - If `shamt[k]` is 1, `work <= {work[DATA_WIDTH-1-2**k:0], work[DATA_WIDTH-1:DATA_WIDTH-2**k]}`, i.e. rotate left by 2**k. Otherwise `work` holds.
  - `k <= k+1`.
  - When the step with `k==SHAMT_WIDTH-1` completes: `a_out <=` the final rotated value, `out_valid <= 1`, state goes to DONE.
- **BUSY, `enable` low:** all registers hold.
- **DONE:**
  - If `out_ready` is high and no new input is accepted, `out_valid <= 0` and state goes to IDLE.
  - If `out_ready` and `in_valid` are both high, the result transfers and the new operand is accepted in the same cycle. `out_valid` is 0 the next cycle, and state goes to BUSY.
- Latency is fixed at `SHAMT_WIDTH` enabled cycles, whatever the shift value. There is no early exit for zero bits.
- Results:
  - Shift 0 returns `a_in` unchanged.
  - Shift 255 equals a rotate right by 1.
  - Rotation is modulo `DATA_WIDTH` by construction.
- `a_out` keeps the last result after the transfer, until the next completion overwrites it.

## Timing
- Reset values:
  - state IDLE
  - `in_ready` 1
  - `out_valid` 0
  - `busy` 0
  - `a_out` 0
  - `work`, `shamt`, `k` all 0
- Reset asserted mid-BUSY or in DONE aborts immediately and asynchronously. The pending result is discarded, with no `out_valid` pulse.
- Accept at edge N: `busy` is high from N to N+`SHAMT_WIDTH`. `out_valid` rises after edge N+`SHAMT_WIDTH`, assuming `enable` is high throughout.
- Each enable-low cycle in BUSY adds exactly one cycle of latency.
- `out_valid` and `a_out` are stable while `out_ready` is low (backpressure). `in_ready` is low during BUSY and during DONE with `out_ready` low.
- Back-to-back throughput is one result per `SHAMT_WIDTH`+1 cycles when `in_valid` is held high.

## Test plan
- **Basic rotate:** `a_in`=256'h1, `shift_in`=1 → `a_out`=256'h2. `out_valid` rises exactly 8 cycles after accept.
- **Wrap:**
  - `a_in`=1<<255, `shift_in`=1 → `a_out`=256'h1.
  - `a_in`=1, `shift_in`=255 → `a_out`=1<<255.
- **Ignored upper bits and identity:** `a_in`=256'hDEADBEEF, `shift_in`=256'h100 → `a_out`=256'hDEADBEEF after 8 cycles.
- **Enable stall and backpressure:**
  - `enable` is low for 3 cycles during BUSY → latency is 11.
  - `out_ready` is held low for 5 cycles → `out_valid` and `a_out` stay stable and `in_ready`=0.
- **Back-to-back:** two operands with `in_valid` held high and `out_ready`=1 → the second is accepted on the cycle the first transfers, with 9-cycle spacing between results.
- **Reset mid-op:** `rst_n` is pulsed low at BUSY step 4 → outputs are immediately at their reset values, there is no `out_valid`, and a subsequent operation is correct.
- **Randomized sweep:** 1000 random operand/shift pairs are checked against a `(a<<s)|(a>>(256-s))` reference model, with random stalls on `enable` and `out_ready`.

Source files
------------

// File: rtl/rotl_iter.sv
// Iterative rotate-left: applies one power-of-two rotate stage per enabled cycle,
// with valid/ready handshakes on both the operand and result ports.
module rotl_iter #(
   parameter int unsigned DATA_WIDTH  = 256,
   parameter int unsigned SHAMT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [DATA_WIDTH-1:0] shift_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] a_out,
   output logic                  busy
);

   localparam int unsigned K_WIDTH = $clog2(SHAMT_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [DATA_WIDTH-1:0]  work;
   logic [DATA_WIDTH-1:0]  work_next;
   logic [DATA_WIDTH-1:0]  work_step;
   logic [SHAMT_WIDTH-1:0] shamt;
   logic [SHAMT_WIDTH-1:0] shamt_next;
   logic [K_WIDTH-1:0]     k;
   logic [K_WIDTH-1:0]     k_next;
   logic [DATA_WIDTH-1:0]  a_out_next;
   logic                   out_valid_next;
   logic                   busy_next;
   logic                   accept;
   logic                   last_step;
   logic                   unused_shift_hi;

   // Upper shift bits carry no meaning; rotation is modulo DATA_WIDTH.
   assign unused_shift_hi = ^shift_in[DATA_WIDTH-1:SHAMT_WIDTH];

   assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign last_step = (k == K_WIDTH'(SHAMT_WIDTH - 1));

   // Single stage: rotate by 2**k when the matching shift bit is set.
   always_comb begin
      work_step = work;
      for (int i = 0; i < SHAMT_WIDTH; i++) begin
         if ((k == K_WIDTH'(i)) && shamt[i]) begin
            work_step = (work << (1 << i)) | (work >> (DATA_WIDTH - (1 << i)));
         end
      end
   end

   always_comb begin
      state_next     = state;
      work_next      = work;
      shamt_next     = shamt;
      k_next         = k;
      a_out_next     = a_out;
      out_valid_next = out_valid;

      case (state)
         BUSY: begin
            if (enable) begin
               work_next = work_step;
               k_next    = k + K_WIDTH'(1);
               if (last_step) begin
                  a_out_next     = work_step;
                  out_valid_next = 1'b1;
                  state_next     = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_next = 1'b0;
               state_next     = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      // A new operand may enter from IDLE or while the previous result drains.
      if (accept) begin
         work_next  = a_in;
         shamt_next = shift_in[SHAMT_WIDTH-1:0];
         k_next     = '0;
         state_next = BUSY;
      end

      busy_next = (state_next == BUSY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         work      <= '0;
         shamt     <= '0;
         k         <= '0;
         a_out     <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         work      <= work_next;
         shamt     <= shamt_next;
         k         <= k_next;
         a_out     <= a_out_next;
         out_valid <= out_valid_next;
         busy      <= busy_next;
      end
   end

endmodule

// File: tb/tb_rotl_iter.sv
// Bench for rotl_iter: directed latency/handshake cases plus a randomized sweep
// scored against a plain rotate reference.
module tb_rotl_iter;

   localparam int unsigned DW = 256;
   localparam int unsigned SW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          enable = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] a_in = '0;
   logic [DW-1:0] shift_in = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] a_out;
   logic          busy;

   int checks = 0;
   int failures = 0;
   int n_results = 0;
   bit rand_mode = 1'b0;
   logic [DW-1:0] exp_q[$];
   bit hold_prev = 1'b0;
   logic [DW-1:0] hold_val = '0;

   rotl_iter #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .shift_in(shift_in),
      .out_valid(out_valid), .out_ready(out_ready), .a_out(a_out), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rotl_ref(input logic [DW-1:0] a, input logic [DW-1:0] s);
      int unsigned n;
      n = int'(s[SW-1:0]);
      return (a << n) | (a >> (DW - n));
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] s);
      bit acc = 1'b0;
      in_valid = 1'b1;
      a_in     = a;
      shift_in = s;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: in_ready stayed low for 200 cycles");
      end
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 200) begin
         step();
         cyc++;
      end
   endtask

   task automatic run_op(input string name, input logic [DW-1:0] a, input logic [DW-1:0] s,
                         input logic [DW-1:0] exp);
      int c;
      out_ready = 1'b0;
      send(a, s);
      check({name, "_busy"}, DW'(busy), DW'(1));
      wait_valid(c);
      check({name, "_latency"}, DW'(c), DW'(8));
      check({name, "_data"}, a_out, exp);
      check({name, "_busy_done"}, DW'(busy), DW'(0));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({name, "_valid_drop"}, DW'(out_valid), DW'(0));
      check({name, "_a_out_kept"}, a_out, exp);
   endtask

   // Scoreboard and protocol rules, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         hold_prev = 1'b0;
      end else begin
         check("in_ready_rule", DW'(in_ready),
               DW'((!busy && !out_valid) || (out_valid && out_ready)));
         if (busy) check("valid_in_busy", DW'(out_valid), DW'(0));
         if (hold_prev) begin
            check("hold_valid", DW'(out_valid), DW'(1));
            check("hold_data", a_out, hold_val);
         end
         if (out_valid && out_ready) begin
            n_results++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result: got %h with nothing outstanding", a_out);
            end else begin
               check("result", a_out, exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) exp_q.push_back(rotl_ref(a_in, shift_in));
         hold_prev = out_valid && !out_ready;
         hold_val  = a_out;
      end
   end

   always @(posedge clk) begin
      if (rand_mode) begin
         #1;
         enable    = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 4) < 3);
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int first;
      int second;
      int acc_at;
      int seen;
      bit acc;
      logic [DW-1:0] first_val;
      logic [DW-1:0] second_val;
      logic [DW-1:0] held;

      #2 rst_n = 1'b0;
      #10;
      check("rst_out_valid", DW'(out_valid), DW'(0));
      check("rst_busy", DW'(busy), DW'(0));
      check("rst_in_ready", DW'(in_ready), DW'(1));
      check("rst_a_out", a_out, '0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      step();

      run_op("basic", 256'h1, 256'h1, 256'h2);
      run_op("wrap_msb", 256'h1 << 255, 256'h1, 256'h1);
      run_op("wrap_255", 256'h1, 256'hFF, 256'h1 << 255);
      run_op("identity", 256'hDEADBEEF, 256'h100, 256'hDEADBEEF);

      // Enable low for three BUSY cycles, then five cycles of backpressure.
      out_ready = 1'b0;
      send(256'h1234, 256'h0F);
      c = 0;
      while (!out_valid && c < 200) begin
         step();
         c++;
         if (c == 2) enable = 1'b0;
         if (c == 4) check("stall_busy", DW'(busy), DW'(1));
         if (c == 5) enable = 1'b1;
      end
      check("stall_latency", DW'(c), DW'(11));
      check("stall_data", a_out, 256'h091A_0000);
      held = a_out;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_valid", DW'(out_valid), DW'(1));
         check("bp_data", a_out, held);
         check("bp_in_ready", DW'(in_ready), DW'(0));
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Back-to-back: second operand accepted on the edge the first result leaves.
      out_ready = 1'b1;
      send(256'hA5, 256'h3);
      in_valid = 1'b1;
      a_in     = 256'hF0F1;
      shift_in = 256'hFF;
      first = -1; second = -1; acc_at = -1;
      first_val = '0; second_val = '0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc && acc_at < 0) begin
            acc_at   = cyc;
            in_valid = 1'b0;
         end
         if (out_valid) begin
            if (first < 0) begin
               first = cyc;
               first_val = a_out;
            end else if (second < 0) begin
               second = cyc;
               second_val = a_out;
            end
         end
      end
      check("b2b_first", DW'(first), DW'(8));
      check("b2b_accept", DW'(acc_at), DW'(9));
      check("b2b_spacing", DW'(second - first), DW'(9));
      check("b2b_data0", first_val, 256'h528);
      check("b2b_data1", second_val, {1'b1, 255'h7878});
      out_ready = 1'b0;

      // Asynchronous reset in the middle of an operation.
      send(256'hFFFF, 256'h5);
      for (int i = 0; i < 4; i++) step();
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", DW'(out_valid), DW'(0));
      check("midrst_busy", DW'(busy), DW'(0));
      check("midrst_in_ready", DW'(in_ready), DW'(1));
      check("midrst_a_out", a_out, '0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (out_valid) seen++;
      end
      check("midrst_no_valid", DW'(seen), DW'(0));
      run_op("post_rst", 256'hC0FFEE, 256'h4, 256'hC0FFEE0);

      // Randomized sweep with random enable and out_ready stalls.
      rand_mode = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         logic [DW-1:0] a;
         logic [DW-1:0] s;
         for (int w = 0; w < 8; w++) a[w*32 +: 32] = $urandom;
         for (int w = 0; w < 8; w++) s[w*32 +: 32] = $urandom;
         if (i == 0) s = '0;
         if (i == 1) s[SW-1:0] = 8'hFF;
         if (i == 2) s[SW-1:0] = 8'h80;
         if (i == 3) s[SW-1:0] = 8'h01;
         send(a, s);
         if ($urandom_range(0, 3) == 0) step();
      end
      rand_mode = 1'b0;
      step();
      step();
      enable    = 1'b1;
      out_ready = 1'b1;
      c = 0;
      while (exp_q.size() != 0 && c < 200) begin
         step();
         c++;
      end
      check("drain", DW'(exp_q.size()), DW'(0));
      check("result_count", DW'(n_results), DW'(1008));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
